csi_ltf_averager: RTL and testbench
===================================

# csi_ltf_averager

Accumulates per-subcarrier complex products from the CSI extractor's complex multiplier across the LTF symbols of one frame. It averages them, scales and saturates them to output width, and streams one CSI vector (one I/Q pair per subcarrier) to the CSI output FIFO. It sits directly downstream of the multiplier, which delivers the LTF-times-reference-conjugate products.

## Interface
- DATA_WIDTH, 32: width of signed input I/Q products
- OUT_WIDTH, 16: width of signed output I/Q
- NUM_SC, 64: subcarriers per symbol; power of two, ≥4
- NUM_SYM, 2: LTF symbols averaged per frame; power of two, 1..8
- OUT_SHIFT, 15: extra arithmetic right shift after averaging (Q15 × Q15 → Q15)

Ports:
- clk_in, input, 1: clock; all logic on the rising edge
- rst_in, input, 1: reset, synchronous, active-high
- s_valid_in, input, 1: input product valid
- s_ready_out, output, 1: block can accept input
- s_sof_in, input, 1: marks subcarrier 0 of the first LTF symbol
- s_i_in / s_q_in, input, DATA_WIDTH signed: product I/Q, subcarriers in index order
- m_valid_out, output, 1: output valid
- m_ready_in, input, 1: downstream accepts output
- m_last_out, output, 1: marks subcarrier NUM_SC-1
- m_i_out / m_q_out, output, OUT_WIDTH signed: averaged CSI
- m_sat_out, output, 1: I or Q of the current beat was saturated

## Operation
- Input transfer: s_valid_in && s_ready_out on a rising edge. Output transfer: m_valid_out && m_ready_in.
- Accumulator RAM: NUM_SC entries × 2 × AW bits, where AW = DATA_WIDTH + log2(NUM_SYM). Counters: sc_idx (log2 NUM_SC bits) and sym_idx.
- IDLE:
  - s_ready_out = 1.
  - A transfer without s_sof_in is dropped.
  - A transfer with s_sof_in writes the sign-extended sample to entry 0, sets sc_idx = 1, sym_idx = 0, and goes to ACCUM.
- ACCUM:
  - s_ready_out = 1.
  - Each transfer at symbol 0 overwrites entry sc_idx; otherwise it adds to entry sc_idx (AW-bit, cannot overflow).
  - sc_idx wraps from NUM_SC-1 to 0 and increments sym_idx.
  - The transfer at sc_idx = NUM_SC-1, sym_idx = NUM_SYM-1 moves to OUTPUT.
  - s_sof_in asserted on any ACCUM transfer restarts the frame: that sample becomes symbol 0, subcarrier 0, and the partial sums are discarded.
- OUTPUT:
  - s_ready_out = 0.
  - Reads entries 0..NUM_SC-1 in order.
  - Each value v is shifted: r = v >>> (log2(NUM_SYM) + OUT_SHIFT), arithmetic shift with floor (truncation).
  - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; m_sat_out = 1 if either component clipped.
  - Return to IDLE on the transfer with m_last_out = 1.
- Backpressure: while m_valid_out && !m_ready_in, m_i_out, m_q_out, m_last_out and m_sat_out hold stable. No beat is lost or duplicated.
- Full-throughput requirement: with m_ready_in held high, NUM_SC consecutive valid beats are produced, one per cycle.

## Timing
- Reset: state IDLE; sc_idx = sym_idx = 0; s_ready_out = 1 from the first cycle after reset; m_valid_out, m_last_out, m_sat_out, m_i_out, m_q_out = 0. RAM contents are don't-care.
- Input: one sample per cycle sustained in IDLE/ACCUM; no bubbles required.
- Latency: s_ready_out drops the cycle after the final input transfer. The first m_valid_out rises 2 cycles after that transfer (1 RAM read plus 1 output register).
- After the last output transfer, s_ready_out = 1 in the next cycle.
- Reset mid-frame or mid-output: the state returns to IDLE next cycle, outputs take their reset values, and the partial frame is dropped.
- Simultaneous s_sof_in and the final ACCUM sample: the restart wins and OUTPUT is not entered.

## Configuration
- CSI_AVG_ROUND_EN:
  - Defined: before the shift, add 2^(log2(NUM_SYM)+OUT_SHIFT-1), i.e. round half up; saturation is applied after rounding.
  - Undefined: plain truncation (floor). The adder is absent.

## Test plan
- Basic average (NUM_SYM=2, OUT_SHIFT=15): every subcarrier gets I = 65536, Q = -65536 in both symbols.
  - Expect 64 beats with I = 2, Q = -2, m_last_out only on beat 63, m_sat_out = 0.
- Saturation: I = 0x4000_0000 in both symbols for subcarrier 5.
  - Expect beat 5: I = 32767, m_sat_out = 1. Other beats: m_sat_out = 0.
- Rounding: subcarrier 0 gets I = 32768 in symbol 0 and I = 0 in symbol 1.
  - Expect I = 0 without CSI_AVG_ROUND_EN, I = 1 with it.
- Backpressure: toggle m_ready_in with a 1-of-3 pattern.
  - Expect all 64 beats delivered once, in order, with data stable across stalled cycles, and s_ready_out = 0 throughout OUTPUT.
- Restart: assert s_sof_in at symbol 1, subcarrier 20, then feed 128 clean samples.
  - Expect output equal to the average of only the clean frame.
- Reset mid-output: assert rst_in during beat 10.
  - Expect m_valid_out = 0 next cycle and s_ready_out = 1. A new frame afterwards produces correct results.

Source files
------------

// File: rtl/csi_ltf_averager.sv
// ---------------------------------------------------------------------------
// csi_ltf_averager: averages per-subcarrier LTF products over NUM_SYM symbols
// and streams one saturated CSI vector per frame. Option: CSI_AVG_ROUND_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csi_ltf_averager #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_SC     = 64,
  parameter int NUM_SYM    = 2,
  parameter int OUT_SHIFT  = 15
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         s_valid_in,
  output logic                         s_ready_out,
  input  logic                         s_sof_in,
  input  logic signed [DATA_WIDTH-1:0] s_i_in,
  input  logic signed [DATA_WIDTH-1:0] s_q_in,
  output logic                         m_valid_out,
  input  logic                         m_ready_in,
  output logic                         m_last_out,
  output logic signed [OUT_WIDTH-1:0]  m_i_out,
  output logic signed [OUT_WIDTH-1:0]  m_q_out,
  output logic                         m_sat_out
);

  localparam int SC_W    = $clog2(NUM_SC);
  localparam int LOG_SYM = $clog2(NUM_SYM);
  localparam int SYM_W   = (LOG_SYM > 0) ? LOG_SYM : 1;
  localparam int AW      = DATA_WIDTH + LOG_SYM;
  localparam int SHIFT   = LOG_SYM + OUT_SHIFT;
  localparam int EW      = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  sc_idx_q, sc_idx_d;
  logic [SYM_W-1:0] sym_idx_q, sym_idx_d;

  logic [2*AW-1:0]  mem_q [NUM_SC];
  logic             wr_en;
  logic [SC_W-1:0]  wr_addr;
  logic [2*AW-1:0]  wr_data;

  logic                 in_xfer;
  logic signed [AW-1:0] in_i_ext, in_q_ext, acc_i, acc_q, sum_i, sum_q;

  logic                 m_valid_q, m_last_q, m_sat_q;
  logic [OUT_WIDTH-1:0] m_i_q, m_q_q;

  assign s_ready_out = (state_q != ST_OUTPUT);
  assign in_xfer     = s_valid_in && s_ready_out;

  assign in_i_ext = AW'(s_i_in);
  assign in_q_ext = AW'(s_q_in);
  assign acc_i    = mem_q[sc_idx_q][2*AW-1:AW];
  assign acc_q    = mem_q[sc_idx_q][AW-1:0];
  assign sum_i    = acc_i + in_i_ext;
  assign sum_q    = acc_q + in_q_ext;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      sc_idx_q  <= '0;
      sym_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sc_idx_q  <= sc_idx_d;
      sym_idx_q <= sym_idx_d;
    end
  end

  // Symbol 0 overwrites the entry so stale sums from earlier frames never leak in.
  always_comb begin
    state_d   = state_q;
    sc_idx_d  = sc_idx_q;
    sym_idx_d = sym_idx_q;
    wr_en     = 1'b0;
    wr_addr   = sc_idx_q;
    wr_data   = {in_i_ext, in_q_ext};
    case (state_q)
      ST_IDLE: begin
        if (in_xfer && s_sof_in) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          sc_idx_d  = SC_W'(1);
          sym_idx_d = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_xfer) begin
          wr_en = 1'b1;
          if (s_sof_in) begin
            wr_addr   = '0;
            sc_idx_d  = SC_W'(1);
            sym_idx_d = '0;
          end else begin
            if (sym_idx_q != '0) wr_data = {sum_i, sum_q};
            sc_idx_d = sc_idx_q + 1'b1;
            if (sc_idx_q == SC_W'(NUM_SC - 1)) begin
              if (sym_idx_q == SYM_W'(NUM_SYM - 1)) begin
                sym_idx_d = '0;
                state_d   = ST_OUTPUT;
              end else begin
                sym_idx_d = sym_idx_q + 1'b1;
              end
            end
          end
        end
      end
      ST_OUTPUT: begin
        if (m_valid_q && m_ready_in && m_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read stage feeding the output register; refills whenever its beat moves on.
  logic [SC_W:0]   rd_cnt_q;
  logic            rd_valid_q, rd_last_q;
  logic [2*AW-1:0] rd_data_q;
  logic            out_adv, rd_issue;

  assign out_adv  = !m_valid_q || m_ready_in;
  assign rd_issue = (state_q == ST_OUTPUT) && (rd_cnt_q != (SC_W+1)'(NUM_SC)) &&
                    (!rd_valid_q || out_adv);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (state_q != ST_OUTPUT) rd_cnt_q <= '0;
      else if (rd_issue)        rd_cnt_q <= rd_cnt_q + 1'b1;
      if (rd_issue) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= mem_q[rd_cnt_q[SC_W-1:0]];
        rd_last_q  <= (rd_cnt_q == (SC_W+1)'(NUM_SC - 1));
      end else if (out_adv) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  function automatic logic [OUT_WIDTH:0] sat_fn(input logic signed [EW-1:0] v);
    logic [EW-OUT_WIDTH:0] hi;
    hi = v[EW-1:OUT_WIDTH-1];
    if ((&hi) || !(|hi)) return {1'b0, v[OUT_WIDTH-1:0]};
    else if (v[EW-1])    return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                 return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction

  logic signed [EW-1:0] ext_i, ext_q, sh_i, sh_q;
  logic [OUT_WIDTH:0]   sat_i, sat_q;

`ifdef CSI_AVG_ROUND_EN
  localparam logic signed [EW-1:0] ROUND = EW'(1) <<< (SHIFT - 1);
  assign ext_i = EW'($signed(rd_data_q[2*AW-1:AW])) + ROUND;
  assign ext_q = EW'($signed(rd_data_q[AW-1:0])) + ROUND;
`else
  assign ext_i = EW'($signed(rd_data_q[2*AW-1:AW]));
  assign ext_q = EW'($signed(rd_data_q[AW-1:0]));
`endif

  assign sh_i  = ext_i >>> SHIFT;
  assign sh_q  = ext_q >>> SHIFT;
  assign sat_i = sat_fn(sh_i);
  assign sat_q = sat_fn(sh_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_sat_q   <= 1'b0;
      m_i_q     <= '0;
      m_q_q     <= '0;
    end else if (out_adv) begin
      m_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        m_last_q <= rd_last_q;
        m_sat_q  <= sat_i[OUT_WIDTH] | sat_q[OUT_WIDTH];
        m_i_q    <= sat_i[OUT_WIDTH-1:0];
        m_q_q    <= sat_q[OUT_WIDTH-1:0];
      end else begin
        m_last_q <= 1'b0;
        m_sat_q  <= 1'b0;
      end
    end
  end

  assign m_valid_out = m_valid_q;
  assign m_last_out  = m_last_q;
  assign m_sat_out   = m_sat_q;
  assign m_i_out     = m_i_q;
  assign m_q_out     = m_q_q;

endmodule

`default_nettype wire

// File: tb/tb_csi_ltf_averager.sv
// ---------------------------------------------------------------------------
// tb_csi_ltf_averager: directed + random frames checked against an
// arithmetic average/saturate reference. Honours CSI_AVG_ROUND_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_csi_ltf_averager;

  localparam int NSC  = 64;
  localparam int NSYM = 2;
  localparam int DW   = 32;
  localparam int OW   = 16;
  localparam int OSH  = 15;
  localparam int SH   = $clog2(NSYM) + OSH;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic                 s_valid_in = 1'b0;
  logic                 s_ready_out;
  logic                 s_sof_in = 1'b0;
  logic signed [DW-1:0] s_i_in = '0;
  logic signed [DW-1:0] s_q_in = '0;
  logic                 m_valid_out;
  logic                 m_ready_in = 1'b1;
  logic                 m_last_out;
  logic signed [OW-1:0] m_i_out;
  logic signed [OW-1:0] m_q_out;
  logic                 m_sat_out;

  csi_ltf_averager #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_SC(NSC), .NUM_SYM(NSYM), .OUT_SHIFT(OSH)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out), .s_sof_in(s_sof_in),
    .s_i_in(s_i_in), .s_q_in(s_q_in),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_last_out(m_last_out),
    .m_i_out(m_i_out), .m_q_out(m_q_out), .m_sat_out(m_sat_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int fi [NSYM][NSC];
  int fq [NSYM][NSC];
  int ei [NSC];
  int eq [NSC];
  bit es [NSC];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Average = sum / 2^SH with floor (or round-half-up), then clip to OW bits.
  function automatic void ref_val(input longint sum, output int v, output bit s);
    longint d, r, hi, lo;
    d  = longint'(1) << SH;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
`ifdef CSI_AVG_ROUND_EN
    sum = sum + d / 2;
`endif
    r = sum / d;
    if ((sum % d) != 0 && sum < 0) r = r - 1;
    s = 1'b0;
    if (r > hi) begin r = hi; s = 1'b1; end
    if (r < lo) begin r = lo; s = 1'b1; end
    v = int'(r);
  endfunction

  function automatic int rand_val();
    case ($urandom_range(0, 2))
      0:       return int'($urandom);
      1:       return int'($urandom) >>> 8;
      default: return int'($urandom_range(0, 1 << 20)) - (1 << 19);
    endcase
  endfunction

  task automatic gen_frame(input int mode);
    for (int s = 0; s < NSYM; s++)
      for (int k = 0; k < NSC; k++) begin
        case (mode)
          1: begin fi[s][k] = 65536; fq[s][k] = -65536; end
          2: begin
            fi[s][k] = int'($urandom_range(0, 1 << 20)) - (1 << 19);
            fq[s][k] = int'($urandom_range(0, 1 << 20)) - (1 << 19);
            if (k == 5) fi[s][k] = 32'h4000_0000;
          end
          3: begin
            fi[s][k] = (s == 0 && k == 0) ? 32768 : 0;
            fq[s][k] = 0;
          end
          default: begin fi[s][k] = rand_val(); fq[s][k] = rand_val(); end
        endcase
      end
    for (int k = 0; k < NSC; k++) begin
      longint si, sq;
      bit a, b;
      si = 0; sq = 0;
      for (int s = 0; s < NSYM; s++) begin si += fi[s][k]; sq += fq[s][k]; end
      ref_val(si, ei[k], a);
      ref_val(sq, eq[k], b);
      es[k] = a | b;
    end
  endtask

  task automatic push(input bit sof, input int i, input int q);
    @(negedge clk_in);
    s_valid_in = 1'b1; s_sof_in = sof; s_i_in = i; s_q_in = q;
  endtask

  // dirty > 0 streams an aborted partial frame before the clean one.
  task automatic send_frame(input int dirty);
    for (int n = 0; n < dirty; n++) push(n == 0, rand_val(), rand_val());
    for (int s = 0; s < NSYM; s++)
      for (int k = 0; k < NSC; k++) push(s == 0 && k == 0, fi[s][k], fq[s][k]);
    @(negedge clk_in);
    s_valid_in = 1'b0; s_sof_in = 1'b0;
    chk("ready_drop", s_ready_out, 1'b0);
    chk("lat_valid_t1", m_valid_out, 1'b0);
    @(negedge clk_in);
    chk("lat_valid_t1b", m_valid_out, 1'b0);
    @(negedge clk_in);
    chk("lat_valid_t2", m_valid_out, 1'b1);
  endtask

  task automatic collect(input bit bp, input int abort);
    int beat, cyc;
    bit stalled, r;
    logic signed [OW-1:0] hi_, hq_;
    logic hl, hs;
    beat = 0; cyc = 0; stalled = 1'b0;
    hi_ = '0; hq_ = '0; hl = 1'b0; hs = 1'b0;
    while (beat < NSC && cyc < 2000) begin
      r = bp ? ((cyc % 3) != 2) : 1'b1;
      if (beat == abort && m_valid_out) break;
      chk("ready_low_in_output", s_ready_out, 1'b0);
      if (m_valid_out) begin
        if (stalled) begin
          chk("hold_i", m_i_out, hi_);
          chk("hold_q", m_q_out, hq_);
          chk("hold_last", m_last_out, hl);
          chk("hold_sat", m_sat_out, hs);
        end
        if (r) begin
          chk($sformatf("beat%0d_i", beat), m_i_out, ei[beat]);
          chk($sformatf("beat%0d_q", beat), m_q_out, eq[beat]);
          chk($sformatf("beat%0d_last", beat), m_last_out, beat == NSC - 1);
          chk($sformatf("beat%0d_sat", beat), m_sat_out, es[beat]);
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hi_ = m_i_out; hq_ = m_q_out; hl = m_last_out; hs = m_sat_out;
        end
      end else begin
        stalled = 1'b0;
      end
      m_ready_in = r;
      @(negedge clk_in);
      cyc++;
    end
    if (abort < 0) begin
      chk("beats_done", beat, NSC);
      if (!bp) chk("throughput_cycles", cyc, NSC);
      chk("ready_after_output", s_ready_out, 1'b1);
      chk("valid_after_output", m_valid_out, 1'b0);
    end
    m_ready_in = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_ready", s_ready_out, 1'b1);
    chk("rst_valid", m_valid_out, 1'b0);
    chk("rst_last", m_last_out, 1'b0);
    chk("rst_sat", m_sat_out, 1'b0);
    chk("rst_i", m_i_out, 0);
    chk("rst_q", m_q_out, 0);

    // Samples without sof in IDLE are ignored.
    push(1'b0, 123, 456);
    push(1'b0, 789, 10);

    gen_frame(1); send_frame(0); collect(1'b0, -1);
    gen_frame(2); send_frame(0); collect(1'b0, -1);
    gen_frame(3); send_frame(0); collect(1'b0, -1);
    gen_frame(0); send_frame(0); collect(1'b1, -1);

    // Restart at symbol 1 / subcarrier 20, then restart on the final sample.
    gen_frame(0); send_frame(NSC + 20); collect(1'b0, -1);
    gen_frame(0); send_frame(NSC * NSYM - 1); collect(1'b1, -1);

    // Reset during beat 10, then a fresh frame.
    gen_frame(0); send_frame(0); collect(1'b0, 10);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_valid", m_valid_out, 1'b0);
    chk("midrst_ready", s_ready_out, 1'b1);
    chk("midrst_last", m_last_out, 1'b0);
    rst_in = 1'b0;
    gen_frame(0); send_frame(0); collect(1'b1, -1);

    for (int n = 0; n < 3; n++) begin
      gen_frame(0); send_frame(0); collect(n[0], -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
